// File: rtl/lfsr_pkg.sv
// Shared LFSR constants: step direction encoding and the maximal-length
// Galois tap masks (right-shifting form) for widths 3..32.
package lfsr_pkg;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int LFSR_MIN_WIDTH = 32'sd3;
    localparam int LFSR_MAX_WIDTH = 32'sd32;

    // Default tap mask for a given width; bit (width-1) is always set.
    function automatic logic [31:0] lfsr_poly(input int width);
        logic [31:0] p;
        case (width)
            32'sd3:  p = 32'h0000_0006;
            32'sd4:  p = 32'h0000_000C;
            32'sd5:  p = 32'h0000_0014;
            32'sd6:  p = 32'h0000_0030;
            32'sd7:  p = 32'h0000_0060;
            32'sd8:  p = 32'h0000_00B8;
            32'sd9:  p = 32'h0000_0110;
            32'sd10: p = 32'h0000_0240;
            32'sd11: p = 32'h0000_0500;
            32'sd12: p = 32'h0000_0829;
            32'sd13: p = 32'h0000_100D;
            32'sd14: p = 32'h0000_2015;
            32'sd15: p = 32'h0000_6000;
            32'sd16: p = 32'h0000_D008;
            32'sd17: p = 32'h0001_2000;
            32'sd18: p = 32'h0002_0400;
            32'sd19: p = 32'h0004_0023;
            32'sd20: p = 32'h0009_0000;
            32'sd21: p = 32'h0014_0000;
            32'sd22: p = 32'h0030_0000;
            32'sd23: p = 32'h0042_0000;
            32'sd24: p = 32'h00E1_0000;
            32'sd25: p = 32'h0120_0000;
            32'sd26: p = 32'h0200_0023;
            32'sd27: p = 32'h0400_0013;
            32'sd28: p = 32'h0900_0000;
            32'sd29: p = 32'h1400_0000;
            32'sd30: p = 32'h2000_0029;
            32'sd31: p = 32'h4800_0000;
            32'sd32: p = 32'h8020_0003;
            default: p = 32'h0000_0000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational Galois LFSR next-state function, forward or reverse.
// The reverse step is the exact inverse of the forward step for nonzero states.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(lfsr_poly(WIDTH))
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] nxt_o
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] fwd_s;
    logic [WIDTH-1:0] rev_s;

    // A forward step that folded in POLY always leaves the MSB set, which is
    // how the reverse step knows to unfold it and restore the shifted-out 1.
    always_comb begin
        fwd_s = (state_i >> 1'b1) ^ (state_i[0] ? POLY : ZERO);
        rev_s = state_i[WIDTH-1] ? (((state_i ^ POLY) << 1'b1) | ONE)
                                 : (state_i << 1'b1);
        case (dir_i)
            DIR_FWD: nxt_o = fwd_s;
            DIR_REV: nxt_o = rev_s;
            default: nxt_o = state_i;
        endcase
    end

endmodule

// File: rtl/lfsr_multi.sv
// Parametrised Galois LFSR with load, fwd/rev stepping, lock-up recovery,
// terminal match and wrap detection. Optional step counter: LFSR_STEP_CNT_EN.
module lfsr_multi
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(lfsr_poly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             cen,
    input  logic             dir,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             wrap,
`ifdef LFSR_STEP_CNT_EN
    output logic             lock,
    output logic [WIDTH-1:0] steps,
    output logic [WIDTH-1:0] period
`else
    output logic             lock
`endif
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic             match_q, match_d;
    logic             wrap_q, wrap_d;
    logic             lock_q, lock_d;
    logic [WIDTH-1:0] nxt_s;

    lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .state_i (count_q),
        .dir_i   (dir),
        .nxt_o   (nxt_s)
    );

    // Next-state selection: load over step; a zero state recovers to SEED.
    always_comb begin
        count_d = count_q;
        start_d = start_q;
        wrap_d  = 1'b0;
        lock_d  = 1'b0;
        if (load) begin
            count_d = data;
            start_d = data;
        end else if (cen) begin
            if (count_q == ZERO) begin
                count_d = SEED;
                start_d = SEED;
                lock_d  = 1'b1;
            end else begin
                count_d = nxt_s;
                wrap_d  = (nxt_s == start_q);
            end
        end else begin
            count_d = count_q;
        end
        match_d = (count_d == term);
    end

    // State and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= SEED;
            start_q <= SEED;
            match_q <= 1'b0;
            wrap_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            start_q <= start_d;
            match_q <= match_d;
            wrap_q  <= wrap_d;
            lock_q  <= lock_d;
        end
    end

    assign count = count_q;
    assign match = match_q;
    assign wrap  = wrap_q;
    assign lock  = lock_q;

`ifdef LFSR_STEP_CNT_EN
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] steps_q, steps_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] steps_inc_s;

    // Saturating step count; the wrapping step itself is included in period.
    always_comb begin
        steps_inc_s = (steps_q == ONES) ? steps_q : (steps_q + ONE);
        steps_d     = steps_q;
        period_d    = period_q;
        if (load || lock_d) begin
            steps_d = ZERO;
        end else if (wrap_d) begin
            period_d = steps_inc_s;
            steps_d  = ZERO;
        end else if (cen) begin
            steps_d = steps_inc_s;
        end else begin
            steps_d = steps_q;
        end
    end

    // Step counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            steps_q  <= ZERO;
            period_q <= ZERO;
        end else begin
            steps_q  <= steps_d;
            period_q <= period_d;
        end
    end

    assign steps  = steps_q;
    assign period = period_q;
`else
`endif

endmodule

// File: tb/tb_lfsr_multi.sv
// Self-checking bench for lfsr_multi (WIDTH=8, POLY=B8). Define
// LFSR_STEP_CNT_EN to also check the steps/period outputs.
module tb_lfsr_multi;

    localparam logic [7:0] SEED = 8'h01;
    localparam logic [7:0] POLY = 8'hB8;

    logic       clk = 1'b0;
    logic       reset, load, cen, dir;
    logic [7:0] data, term;
    logic [7:0] count;
    logic       match, wrap, lock;
`ifdef LFSR_STEP_CNT_EN
    logic [7:0] steps, period;
`endif

    lfsr_multi dut (
        .clk    (clk),
        .reset  (reset),
        .data   (data),
        .load   (load),
        .cen    (cen),
        .dir    (dir),
        .term   (term),
        .count  (count),
        .match  (match),
        .wrap   (wrap),
`ifdef LFSR_STEP_CNT_EN
        .lock   (lock),
        .steps  (steps),
        .period (period)
`else
        .lock   (lock)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the forward map comes from the step rule; reverse is its inverse table.
    logic [7:0] succ [256];
    logic [7:0] pred [256];
    logic [7:0] m_cnt, m_start;
    logic       m_match, m_wrap, m_lock;
    int         m_steps, m_period;

    always @(posedge clk) begin
        m_wrap = 1'b0;
        m_lock = 1'b0;
        if (reset) begin
            m_cnt = SEED; m_start = SEED; m_steps = 0; m_period = 0;
        end else if (load) begin
            m_cnt = data; m_start = data; m_steps = 0;
        end else if (cen && m_cnt == 8'h00) begin
            m_cnt = SEED; m_start = SEED; m_lock = 1'b1; m_steps = 0;
        end else if (cen) begin
            m_cnt   = dir ? pred[m_cnt] : succ[m_cnt];
            m_steps = (m_steps < 255) ? m_steps + 1 : 255;
            if (m_cnt == m_start) begin
                m_wrap = 1'b1; m_period = m_steps; m_steps = 0;
            end
        end
        m_match = !reset && (m_cnt == term);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_count", count, m_cnt);
            chk("cmp_match", match, m_match);
            chk("cmp_wrap",  wrap,  m_wrap);
            chk("cmp_lock",  lock,  m_lock);
`ifdef LFSR_STEP_CNT_EN
            chk("cmp_steps",  steps,  m_steps);
            chk("cmp_period", period, m_period);
`endif
        end
    end

    task automatic cyc(input logic rs, input logic ld, input logic [7:0] d,
                       input logic ce, input logic dr);
        reset = rs; load = ld; data = d; cen = ce; dir = dr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] t1_exp [5];
        logic [7:0] v;
        int         wraps;
        logic       last_wrap;

        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            succ[i] = (v >> 1) ^ (v[0] ? POLY : 8'h00);
        end
        pred[0] = 8'h00;
        for (int i = 1; i < 256; i++) pred[succ[i]] = 8'(i);

        reset = 1'b1; load = 1'b0; cen = 1'b0; dir = 1'b0;
        data = 8'h00; term = 8'h2E;

        // 1. Reset state and first five forward steps; term=2E covers match.
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("rst_count", count, 8'h01);
        chk("rst_match", match, 1'b0);
        chk("rst_wrap",  wrap,  1'b0);
        chk("rst_lock",  lock,  1'b0);
`ifdef LFSR_STEP_CNT_EN
        chk("rst_period", period, 8'h00);
`endif
        t1_exp = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            chk("t1_count", count, t1_exp[i]);
            chk("t1_match", match, (i == 2) ? 1'b1 : 1'b0);
            chk("t1_wrap",  wrap,  1'b0);
        end

        // 2. Full forward period from 01, then full reverse period.
        for (int pass = 0; pass < 2; pass++) begin
            cyc(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
            wraps = 0;
            last_wrap = 1'b0;
            for (int i = 0; i < 255; i++) begin
                cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'(pass));
                if (wrap === 1'b1) wraps++;
                last_wrap = wrap;
            end
            chk("t2_count_end", count, 8'h01);
            chk("t2_wrap_once", 32'(wraps), 32'd1);
            chk("t2_wrap_last", last_wrap, 1'b1);
`ifdef LFSR_STEP_CNT_EN
            chk("t2_period", period, 8'd255);
`endif
        end

        // 3. Reverse from B8, then forward+reverse round trips.
        cyc(1'b0, 1'b1, 8'hB8, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("t3_rev_b8", count, 8'h01);
        for (int i = 0; i < 100; i++) begin
            v = 8'($urandom_range(255, 1));
            cyc(1'b0, 1'b1, v, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            chk("t3_roundtrip", count, v);
        end

        // 4. Zero load, hold, lock-up recovery, load beats cen.
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("t4_load0", count, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_hold0", count, 8'h00);
        chk("t4_nolock", lock, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_recover", count, 8'h01);
        chk("t4_lock", lock, 1'b1);
        chk("t4_nowrap", wrap, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_lock_pulse", lock, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        chk("t4_load_wins", count, 8'h00);
        chk("t4_load_nolock", lock, 1'b0);

        // 6. Reset mid-sequence with cen high, then reset beats load.
        cyc(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_pre", count, 8'h2E);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_rst_count", count, 8'h01);
        chk("t6_rst_wrap",  wrap,  1'b0);
        chk("t6_rst_lock",  lock,  1'b0);
        chk("t6_rst_match", match, 1'b0);
        cyc(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        chk("t6_rst_wins", count, 8'h01);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
